// File: rtl/serial_subtractor_fsm_pkg.sv
// serial_subtractor_fsm_pkg: shared state encoding and default width for the bit-serial subtractor
package serial_subtractor_fsm_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor_fsm_full_subtractor_bl.sv
// full_subtractor_bl: one-bit combinational full subtractor cell
//   a, b  : minuend / subtrahend bit
//   bin   : borrow in
//   d     : difference bit a - b - bin
//   bout  : borrow out
module full_subtractor_bl (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor_fsm.sv
// serial_subtractor_fsm: bit-serial WIDTH-bit subtractor (ip1 - ip2), LSB first, start/busy/done handshake
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : request, sampled only in IDLE
//   ip1, ip2    : minuend / subtrahend, captured on the accepting edge
//   diff        : registered result, updated when the last bit is produced
//   borrow      : final borrow-out (ip1 < ip2, unsigned)
//   busy        : high in RUN and DONE
//   done        : one-cycle pulse in DONE
//   SERIAL_SUB_SAT_EN : when defined, diff floors to 0 whenever the final borrow is set
module serial_subtractor_fsm
  import serial_subtractor_fsm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic [WIDTH-2:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_bff, r_borrow;
  logic             w_d, w_bo, w_last;
  logic [WIDTH-1:0] w_shift, w_final;
  full_subtractor_bl u_cell (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .bin (r_bff),
    .d   (w_d),
    .bout(w_bo)
  );
  assign w_last  = r_cnt == CW'(WIDTH - 1);
  // partial result holds the WIDTH-1 bits produced so far; the new bit enters at the top
  assign w_shift = {w_d, r_res};
`ifdef SERIAL_SUB_SAT_EN
  assign w_final = w_bo ? '0 : w_shift;
`else
  assign w_final = w_shift;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = ST_IDLE;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: w_next = start ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        w_next = w_last ? ST_DONE : ST_RUN;
        busy   = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_bff    <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (start) begin
            r_a   <= ip1;
            r_b   <= ip2;
            r_res <= '0;
            r_bff <= 1'b0;
            r_cnt <= '0;
          end
        ST_RUN: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_res <= w_shift[WIDTH-1:1];
          r_bff <= w_bo;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff   <= w_final;
            r_borrow <= w_bo;
          end
        end
        ST_DONE: ;
        default: begin
          r_diff   <= '0;
          r_borrow <= 1'b0;
        end
      endcase
    end
  end
  assign diff   = r_diff;
  assign borrow = r_borrow;
endmodule

// File: tb/tb_serial_subtractor_fsm.sv
// tb_serial_subtractor_fsm: scoreboard bench with randomized and directed operations against an arithmetic model
module tb_serial_subtractor_fsm;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] d;
    logic         b;
    int           acc;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] ip1 = '0, ip2 = '0;
  logic [W-1:0] diff;
  logic         borrow, busy, done;
  exp_t         q[$];
  exp_t         m_e;
  int           checks = 0, failures = 0, cyc = 0, busy_len = 0;
  serial_subtractor_fsm #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ip1   (ip1),
    .ip2   (ip2),
    .diff  (diff),
    .borrow(borrow),
    .busy  (busy),
    .done  (done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    int   r;
    r     = int'(a) - int'(b);
    e.b   = r < 0;
    e.d   = W'(e.b ? r + (1 << W) : r);
`ifdef SERIAL_SUB_SAT_EN
    if (e.b) e.d = '0;
`endif
    e.acc = acc;
    return e;
  endfunction
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) busy_len = 0;
    else begin
      if (busy) busy_len++;
      else if (busy_len != 0) begin
        check("busy_length", busy_len, W + 1);
        busy_len = 0;
      end
      if (done) begin
        if (q.size() == 0) check("spurious_done", 1, 0);
        else begin
          m_e = q.pop_front();
          check("diff", int'(diff), int'(m_e.d));
          check("borrow", int'(borrow), int'(m_e.b));
          check("done_latency", cyc, m_e.acc + W);
          check("busy_at_done", int'(busy), 1);
        end
      end
    end
  end
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    start = 1'b1;
    ip1   = a;
    ip2   = b;
    q.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    ip1   = W'($urandom);
    ip2   = W'($urandom);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_diff"}, int'(diff), 0);
    check({tag, "_borrow"}, int'(borrow), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask
  initial begin
    int n;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd200, 8'd55);
    issue(8'd10, 8'd20);
    issue(8'h00, 8'hFF);
    issue(8'h5A, 8'h5A);
    issue(8'hFF, 8'h00);
    issue(8'd100, 8'd30);
    repeat (3) @(negedge clk);
    start = 1'b1;
    ip1   = 8'd7;
    ip2   = 8'd99;
    @(negedge clk);
    start = 1'b0;
    issue(8'd77, 8'd33);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd50, 8'd49);
    wait_idle();
    start = 1'b1;
    ip1   = 8'd123;
    ip2   = 8'd45;
    repeat (30) begin
      if (!busy) q.push_back(model(ip1, ip2, cyc + 1));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (40) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = ($urandom_range(0, 4) == 0) ? a : W'($urandom);
      issue(a, b);
    end
    n = 0;
    while ((q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_done actual=%0d pending required=0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
